// File: rtl/ldt_diff_rx_deser_if.sv
// rtl/ldt_diff_rx_deser_if.sv - pad-side pairs and core-side word outputs of the LDT receive deserialiser
interface ldt_diff_rx_deser_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic             i_en;
    logic             i_i;
    logic             i_ib;
    logic             i_ctl;
    logic             i_ctlb;
    logic [WIDTH-1:0] o_d;
    logic             o_dvalid;
    logic             o_sync;
    logic             o_perr;
    logic             o_ferr;
    logic [CNTW-1:0]  o_errcnt;

    modport master (
        output i_en, i_i, i_ib, i_ctl, i_ctlb,
        input  o_d, o_dvalid, o_sync, o_perr, o_ferr, o_errcnt
    );

    modport slave (
        input  i_en, i_i, i_ib, i_ctl, i_ctlb,
        output o_d, o_dvalid, o_sync, o_perr, o_ferr, o_errcnt
    );
endinterface

// File: rtl/ldt_diff_rx_deser.sv
// rtl/ldt_diff_rx_deser.sv - LDT differential receive: pair check, CTL framing, LSB-first deserialiser
module ldt_diff_rx_deser #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ldt_diff_rx_deser_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {ST_HUNT, ST_SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_i_q, r_ib_q, r_ctl_q, r_ctlb_q;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic             r_dvalid, w_dvalid_nxt;
    logic             r_sync, w_sync_nxt;
    logic             r_perr, w_perr_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic [CNTW-1:0]  r_errcnt;
    logic             w_err_evt;
    logic             w_valid;
    logic             w_mark;

    assign w_valid = (r_i_q != r_ib_q) && (r_ctl_q != r_ctlb_q);
    assign w_mark  = r_ctl_q;

    // Bits enter at the MSB and walk down, so after WIDTH bits the first one sits at D[0].
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_d_nxt      = r_d;
        w_dvalid_nxt = 1'b0;
        w_sync_nxt   = 1'b0;
        w_perr_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_err_evt    = 1'b0;
        if (!bus.i_en) begin
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = '0;
        end else if (!w_valid) begin
            w_perr_nxt  = 1'b1;
            w_err_evt   = 1'b1;
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_mark) begin
                        w_shift_nxt = {r_i_q, {(WIDTH-1){1'b0}}};
                        w_cnt_nxt   = CW'(1);
                        w_sync_nxt  = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_sync_nxt = 1'b1;
                    if (w_mark) begin
                        // Mid-word mark: drop the partial word and treat this bit as a fresh bit 0.
                        w_ferr_nxt  = 1'b1;
                        w_err_evt   = 1'b1;
                        w_shift_nxt = {r_i_q, {(WIDTH-1){1'b0}}};
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_shift_nxt = {r_i_q, r_shift[WIDTH-1:1]};
                        if (r_cnt == LAST) begin
                            w_d_nxt      = {r_i_q, r_shift[WIDTH-1:1]};
                            w_dvalid_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = ST_HUNT;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i_q    <= 1'b0;
            r_ib_q   <= 1'b0;
            r_ctl_q  <= 1'b0;
            r_ctlb_q <= 1'b0;
            r_state  <= ST_HUNT;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_d      <= '0;
            r_dvalid <= 1'b0;
            r_sync   <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_i_q    <= bus.i_i;
            r_ib_q   <= bus.i_ib;
            r_ctl_q  <= bus.i_ctl;
            r_ctlb_q <= bus.i_ctlb;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_d      <= w_d_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_sync   <= w_sync_nxt;
            r_perr   <= w_perr_nxt;
            r_ferr   <= w_ferr_nxt;
            if (w_err_evt && (r_errcnt != {CNTW{1'b1}})) begin
                r_errcnt <= r_errcnt + CNTW'(1);
            end
        end
    end

    assign bus.o_d      = r_d;
    assign bus.o_dvalid = r_dvalid;
    assign bus.o_sync   = r_sync;
    assign bus.o_perr   = r_perr;
    assign bus.o_ferr   = r_ferr;
    assign bus.o_errcnt = r_errcnt;
endmodule

// File: tb/tb_ldt_diff_rx_deser.sv
// tb/tb_ldt_diff_rx_deser.sv - scoreboard bench for the LDT receive deserialiser
module tb_ldt_diff_rx_deser;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   dv_seen;
    int   perr_seen;
    int   ferr_seen;
    int   sync_run;
    int   last_sync;
    int   exp_err;
    logic prev_dv;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;
    exp_t q[$];

    ldt_diff_rx_deser_if #(.WIDTH(8), .CNTW(8)) bus ();

    ldt_diff_rx_deser #(.WIDTH(8), .CNTW(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic b, input logic c, input logic bad);
        @(negedge clk);
        bus.i_i    = b;
        bus.i_ib   = bad ? b : ~b;
        bus.i_ctl  = c;
        bus.i_ctlb = ~c;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            drive(w[k], k == 0, 1'b0);
            if (k == 0) q.push_back('{d: w, cyc: cyc + 9});
        end
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    always @(negedge clk) begin
        if (bus.o_dvalid) begin
            dv_seen++;
            chk("dvalid_width", {31'd0, prev_dv}, 32'd0);
            chk("dvalid_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("word", {24'd0, bus.o_d}, {24'd0, e.d});
                chk("latency", cyc, e.cyc);
            end
        end
        prev_dv = bus.o_dvalid;
        if (bus.o_perr) perr_seen++;
        if (bus.o_ferr) ferr_seen++;
        if (bus.o_sync) sync_run++;
        else if (sync_run != 0) begin
            last_sync = sync_run;
            sync_run  = 0;
        end
    end

    initial begin
        int dv0, pe0, fe0;
        n_chk = 0; n_pass = 0; dv_seen = 0; perr_seen = 0; ferr_seen = 0;
        sync_run = 0; last_sync = 0; exp_err = 0; prev_dv = 1'b0; cyc = 0;
        rst_n = 1'b0;
        bus.i_en = 1'b0;
        bus.i_i = 1'b0; bus.i_ib = 1'b1; bus.i_ctl = 1'b0; bus.i_ctlb = 1'b1;
        #1;
        chk("rst_d", {24'd0, bus.o_d}, 32'd0);
        chk("rst_dvalid", {31'd0, bus.o_dvalid}, 32'd0);
        chk("rst_sync", {31'd0, bus.o_sync}, 32'd0);
        chk("rst_perr", {31'd0, bus.o_perr}, 32'd0);
        chk("rst_ferr", {31'd0, bus.o_ferr}, 32'd0);
        chk("rst_errcnt", {24'd0, bus.o_errcnt}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        bus.i_en = 1'b1;
        idle(2);

        // single framed word
        send_word(8'hA5);
        idle(12);
        chk("t1_dv", dv_seen, 1);
        chk("t1_sync_len", last_sync, 8);
        chk("t1_errcnt", {24'd0, bus.o_errcnt}, exp_err);

        // back-to-back words
        send_word(8'h3C);
        send_word(8'hC3);
        idle(12);
        chk("t2_dv", dv_seen, 3);
        chk("t2_sync_len", last_sync, 16);
        chk("t2_d_hold", {24'd0, bus.o_d}, 32'hC3);

        // pair error on bit 3
        dv0 = dv_seen; pe0 = perr_seen;
        for (int k = 0; k < 8; k++) drive(1'b1, k == 0, k == 3);
        bump_err();
        idle(4);
        chk("t3_perr", perr_seen - pe0, 1);
        chk("t3_no_dv", dv_seen - dv0, 0);
        chk("t3_errcnt", {24'd0, bus.o_errcnt}, exp_err);
        send_word(8'h12);
        idle(12);
        chk("t3_recover_dv", dv_seen - dv0, 1);

        // mark on bit 5 restarts the word
        dv0 = dv_seen; fe0 = ferr_seen;
        for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b0);
        send_word(8'h81);
        bump_err();
        idle(12);
        chk("t4_ferr", ferr_seen - fe0, 1);
        chk("t4_dv", dv_seen - dv0, 1);
        chk("t4_errcnt", {24'd0, bus.o_errcnt}, exp_err);

        // reset mid-word
        dv0 = dv_seen;
        for (int k = 0; k < 5; k++) drive(k[0], k == 0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_err = 0;
        #1;
        chk("t5_d", {24'd0, bus.o_d}, 32'd0);
        chk("t5_dvalid", {31'd0, bus.o_dvalid}, 32'd0);
        chk("t5_errcnt", {24'd0, bus.o_errcnt}, exp_err);
        bus.i_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        bus.i_en = 1'b1;
        idle(2);
        chk("t5_no_dv", dv_seen - dv0, 0);
        send_word(8'h5A);
        idle(12);
        chk("t5_dv", dv_seen - dv0, 1);
        chk("t5_d_new", {24'd0, bus.o_d}, 32'h5A);

        // error counter saturation
        pe0 = perr_seen;
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            bump_err();
        end
        idle(4);
        chk("t6_perr_cnt", perr_seen - pe0, 300);
        chk("t6_errcnt_sat", {24'd0, bus.o_errcnt}, exp_err);
        idle(3);
        chk("t6_errcnt_hold", {24'd0, bus.o_errcnt}, 32'd255);

        // disabled receiver ignores the pins
        dv0 = dv_seen; pe0 = perr_seen;
        @(negedge clk);
        bus.i_en = 1'b0;
        for (int k = 0; k < 8; k++) drive(k[0], k == 0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b1);
        idle(12);
        chk("t6_en0_dv", dv_seen - dv0, 0);
        chk("t6_en0_perr", perr_seen - pe0, 0);
        chk("t6_en0_sync", {31'd0, bus.o_sync}, 32'd0);
        chk("final_q_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
